// File: rtl/quan_pack_ctrl.sv
// Sequencer around the combinational Lloyd quantizer: feeds samples, captures codes, packs them into words.
// Latency: sample accept -> code capture 2 clocks; full word valid the cycle after the 4th code is captured.
// Backpressure: s_ready drops in EVAL, while a flush is pending, and when a held word would be overwritten.
module quan_pack_ctrl #(
    parameter int IN_WIDTH       = 16,
    parameter int CODE_WIDTH     = 4,
    parameter int CODES_PER_WORD = 4,
    localparam int OUT_WIDTH     = CODE_WIDTH * CODES_PER_WORD,
    localparam int CNT_W         = $clog2(CODES_PER_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  flush,
    output logic [IN_WIDTH-1:0]   quan_in,
    input  logic [CODE_WIDTH-1:0] quan_code,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic [2:0]            m_ncodes,
    output logic                  busy
);

    typedef enum logic {IDLE, EVAL} state_t;

    localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(CODES_PER_WORD - 1);
    localparam logic [IN_WIDTH-1:0] ALL_ONES  = {IN_WIDTH{1'b1}};
    localparam logic [IN_WIDTH-1:0] CLAMP_VAL = ALL_ONES - IN_WIDTH'(1);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [OUT_WIDTH-1:0]    pack_q;
    logic                    flush_pend_q;
    logic [IN_WIDTH-1:0]     quan_in_q;
    logic                    m_valid_q;
    logic [OUT_WIDTH-1:0]    m_data_q;
    logic [2:0]              m_ncodes_q;

    logic                    accept;
    logic                    out_free;
    logic [IN_WIDTH-1:0]     sample_d;

    // Handshake qualifiers; the last code of a word is refused while the output slot is still occupied.
    always_comb begin
        s_ready  = (state_q == IDLE) && !flush_pend_q && !(m_valid_q && (cnt_q == LAST_CNT));
        accept   = s_valid && s_ready;
        out_free = !m_valid_q || m_ready;
        // The quantizer table has no entry for all-ones, so it is folded onto the top mapped value.
        sample_d = (s_data == ALL_ONES) ? CLAMP_VAL : s_data;
    end

    // Sequencer, packer and output register; later assignments override the m_valid clear on reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pack_q       <= '0;
            flush_pend_q <= 1'b0;
            quan_in_q    <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_ncodes_q   <= '0;
        end else begin
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            // Remember a flush only when there is (or is about to be) a code to emit.
            if (flush && ((cnt_q != '0) || (state_q == EVAL) || accept)) begin
                flush_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (flush_pend_q) begin
                        if (out_free) begin
                            if (cnt_q != '0) begin
                                m_data_q   <= pack_q;
                                m_ncodes_q <= 3'(cnt_q);
                                m_valid_q  <= 1'b1;
                                cnt_q      <= '0;
                                pack_q     <= '0;
                            end
                            flush_pend_q <= 1'b0;
                        end
                    end else if (accept) begin
                        quan_in_q <= sample_d;
                        state_q   <= EVAL;
                    end
                end
                EVAL: begin
                    state_q <= IDLE;
                    pack_q[cnt_q*CODE_WIDTH +: CODE_WIDTH] <= quan_code;
                    if (cnt_q == LAST_CNT) begin
                        m_data_q   <= {quan_code, pack_q[OUT_WIDTH-CODE_WIDTH-1:0]};
                        m_ncodes_q <= 3'(CODES_PER_WORD);
                        m_valid_q  <= 1'b1;
                        cnt_q      <= '0;
                        pack_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered outputs and activity flag.
    always_comb begin
        quan_in  = quan_in_q;
        m_valid  = m_valid_q;
        m_data   = m_data_q;
        m_ncodes = m_ncodes_q;
        busy     = (state_q != IDLE) || (cnt_q != '0) || flush_pend_q;
    end

endmodule
